// File: rtl/scan_rr_arbiter_pkg.sv
// scan_rr_pkg: state encoding, chain geometry helpers and one-hot decode for the scan round-robin arbiter
package scan_rr_pkg;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;
    function automatic int ptr_w(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction
    function automatic int chain_len(input int n_ch, input int hold_w);
        return 1 + ptr_w(n_ch) + hold_w + n_ch;
    endfunction
    function automatic int onehot_idx(input logic [31:0] v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if (v[i]) r = i;
        return r;
    endfunction
endpackage

// File: rtl/scan_rr_arbiter_if.sv
// scan_rr_arbiter_if: arbiter bus (req, lock in; gnt, busy out) with master/slave views
interface scan_rr_arbiter_if #(parameter int N_CH = 4);
    logic [N_CH-1:0] req;
    logic            lock;
    logic [N_CH-1:0] gnt;
    logic            busy;
    modport master (output req, lock, input gnt, busy);
    modport slave  (input req, lock, output gnt, busy);
endinterface

// File: rtl/scan_rr_arbiter_rr_pick.sv
// rr_pick: circular priority search from start (out-of-range start treated as 0); index/found out
module rr_pick #(
    parameter int N_CH  = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [PTR_W-1:0] start,
    output logic [PTR_W-1:0] index,
    output logic             found
);
    logic [PTR_W-1:0] s;
    always_comb begin
        s = (int'(start) < N_CH) ? start : '0;
        index = '0;
        found = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (req[(int'(s) + k) % N_CH]) begin
                index = PTR_W'((int'(s) + k) % N_CH);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/scan_rr_arbiter.sv
// scan_rr_arbiter: round-robin arbiter with hold-limit preemption and full scan (CK, RST, SE, SI, SO; req/lock/gnt/busy via bus)
module scan_rr_arbiter
    import scan_rr_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int HOLD_W   = 3,
    parameter int MAX_HOLD = 5
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              SE,
    input  logic              SI,
    output logic              SO,
    scan_rr_arbiter_if.slave  bus
);
    localparam int PTR_W = ptr_w(N_CH);
    localparam int L     = chain_len(N_CH, HOLD_W);
    localparam logic [N_CH-1:0]   ONE   = N_CH'(1);
    localparam logic [HOLD_W-1:0] C_MAX = HOLD_W'(MAX_HOLD - 1);
    logic [L-1:0]      chain;
    logic [0:0]        st, st_n;
    logic [PTR_W-1:0]  ptr, ptr_n, g, g_inc, idle_idx, pre_idx;
    logic [HOLD_W-1:0] cnt, cnt_n;
    logic [N_CH-1:0]   gnt, gnt_n;
    logic              idle_found, pre_found;
    // chain bit 0 is st, the top bit is gnt[N_CH-1] which drives SO
    assign st  = chain[0];
    assign ptr = chain[PTR_W:1];
    assign cnt = chain[PTR_W+HOLD_W:PTR_W+1];
    assign gnt = chain[L-1:L-N_CH];
    assign SO  = chain[L-1];
    assign bus.gnt  = gnt;
    assign bus.busy = |gnt;
    assign g     = PTR_W'(onehot_idx(32'(gnt)));
    assign g_inc = (int'(g) == N_CH - 1) ? '0 : g + 1'b1;
    rr_pick #(.N_CH(N_CH), .PTR_W(PTR_W)) u_pick_idle (.req(bus.req), .start(ptr), .index(idle_idx), .found(idle_found));
    rr_pick #(.N_CH(N_CH), .PTR_W(PTR_W)) u_pick_pre (.req(bus.req), .start(g_inc), .index(pre_idx), .found(pre_found));
    always_comb begin
        st_n  = st;
        ptr_n = ptr;
        cnt_n = cnt;
        gnt_n = gnt;
        if (st == ST_IDLE) begin
            gnt_n = idle_found ? ONE << idle_idx : '0;
            st_n  = idle_found ? ST_GRANT : ST_IDLE;
            cnt_n = idle_found ? '0 : cnt;
        end else if (!$onehot(gnt)) begin
            gnt_n = '0;
            st_n  = ST_IDLE;
        end else if (!bus.req[g]) begin
            gnt_n = '0;
            ptr_n = g_inc;
            st_n  = ST_IDLE;
        end else if (!bus.lock && cnt == C_MAX && pre_found && |(bus.req & ~gnt)) begin
            gnt_n = ONE << pre_idx;
            ptr_n = g_inc;
            cnt_n = '0;
        end else begin
            // a scan-loaded count above the limit is clamped so preemption still happens
            cnt_n = (cnt >= C_MAX) ? C_MAX : cnt + 1'b1;
        end
    end
    always_ff @(posedge CK or posedge RST) begin
        if (RST) chain <= '0;
        else     chain <= SE ? {chain[L-2:0], SI} : {gnt_n, cnt_n, ptr_n, st_n};
    end
endmodule

// File: tb/tb_scan_rr_arbiter.sv
// tb_scan_rr_arbiter: randomized and directed checks of scan_rr_arbiter against a behavioural model
module tb_scan_rr_arbiter;
    localparam int N  = 4;
    localparam int MH = 5;
    logic clk = 1'b0, rst = 1'b1, se = 1'b0, si = 1'b0, so;
    int tests = 0, errors = 0;
    bit m_st;
    int m_ptr, m_cnt;
    logic [N-1:0] m_gnt;
    scan_rr_arbiter_if #(.N_CH(N)) bus ();
    scan_rr_arbiter #(.N_CH(N), .HOLD_W(3), .MAX_HOLD(MH)) dut (
        .CK(clk), .RST(rst), .SE(se), .SI(si), .SO(so), .bus(bus)
    );
    always #5 clk = ~clk;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
    function automatic int pick(input logic [N-1:0] r, input int s);
        int b;
        b = (s >= N) ? 0 : s;
        for (int k = 0; k < N; k++)
            if (r[(b + k) % N]) return (b + k) % N;
        return 0;
    endfunction
    function automatic int owner(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return 0;
    endfunction
    function automatic logic [11:0] exp_vec();
        return {m_st, 2'(m_ptr), 3'(m_cnt), m_gnt, |m_gnt, m_gnt[N-1]};
    endfunction
    function automatic logic [11:0] obs_vec();
        return {dut.st, dut.ptr, dut.cnt, bus.gnt, bus.busy, so};
    endfunction
    task automatic model_reset();
        m_st = 0;
        m_ptr = 0;
        m_cnt = 0;
        m_gnt = '0;
    endtask
    task automatic model_step();
        logic [9:0] c;
        int g;
        if (se) begin
            c = {m_gnt, 3'(m_cnt), 2'(m_ptr), m_st};
            c = {c[8:0], si};
            m_st = c[0];
            m_ptr = int'(c[2:1]);
            m_cnt = int'(c[5:3]);
            m_gnt = c[9:6];
        end else if (!m_st) begin
            if (bus.req != '0) begin
                m_gnt = N'(1) << pick(bus.req, m_ptr);
                m_st = 1;
                m_cnt = 0;
            end else m_gnt = '0;
        end else if ($countones(m_gnt) != 1) begin
            m_gnt = '0;
            m_st = 0;
        end else begin
            g = owner(m_gnt);
            if (!bus.req[g]) begin
                m_gnt = '0;
                m_ptr = (g + 1) % N;
                m_st = 0;
            end else if (!bus.lock && m_cnt == MH - 1 && (bus.req & ~m_gnt) != '0) begin
                m_ptr = (g + 1) % N;
                m_gnt = N'(1) << pick(bus.req, m_ptr);
                m_cnt = 0;
            end else m_cnt = (m_cnt >= MH - 1) ? MH - 1 : m_cnt + 1;
        end
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask
    task automatic do_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
    endtask
    task automatic test_reset();
        bus.req = '0;
        bus.lock = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        se = 1'b1;
        si = 1'b1;
        repeat (10) tick();
        se = 1'b0;
        si = 1'b0;
        tests++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL scan_fill: got %b required %b", obs_vec(), exp_vec());
        end
        #2 rst = 1'b1;
        #1 model_reset();
        tests++;
        if ({bus.gnt, bus.busy, so} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: got gnt/busy/so=%b required 000000", {bus.gnt, bus.busy, so});
        end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec() || bus.gnt !== '0) begin
                errors++;
                $display("FAIL reset_idle c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
        end
    endtask
    task automatic test_single();
        do_reset();
        bus.req = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec() || bus.gnt !== 4'b0100) begin
                errors++;
                $display("FAIL single_grant c%0d: got %b required %b gnt 0100", c, obs_vec(), exp_vec());
            end
        end
        bus.req = '0;
        tick();
        tests++;
        if (obs_vec() !== exp_vec() || bus.gnt !== '0 || dut.ptr !== 2'd3) begin
            errors++;
            $display("FAIL single_release: got %b required %b ptr 3", obs_vec(), exp_vec());
        end
        tick();
        tests++;
        if (obs_vec() !== exp_vec() || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got %b required %b", obs_vec(), exp_vec());
        end
    endtask
    task automatic test_rotation();
        logic [N-1:0] order [4];
        order = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req = 4'b1011;
            for (int c = 0; c < 2; c++) begin
                tick();
                tests++;
                if (obs_vec() !== exp_vec() || bus.gnt !== order[i]) begin
                    errors++;
                    $display("FAIL rotation_grant %0d/%0d: got %b gnt %b required %b gnt %b", i, c, obs_vec(), bus.gnt, exp_vec(), order[i]);
                end
            end
            bus.req = 4'b1011 & ~order[i];
            tick();
            tests++;
            if (obs_vec() !== exp_vec() || bus.gnt !== '0) begin
                errors++;
                $display("FAIL rotation_gap %0d: got %b required %b", i, obs_vec(), exp_vec());
            end
        end
    endtask
    task automatic test_preempt();
        do_reset();
        bus.lock = 1'b0;
        bus.req = 4'b0011;
        for (int c = 0; c < 16; c++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec() || bus.gnt !== (((c / MH) % 2) ? 4'b0010 : 4'b0001)) begin
                errors++;
                $display("FAIL preempt c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
        end
    endtask
    task automatic test_lock();
        do_reset();
        bus.lock = 1'b1;
        bus.req = 4'b0011;
        for (int c = 0; c < 20; c++) begin
            tick();
            tests++;
            if (obs_vec() !== exp_vec() || bus.gnt !== 4'b0001 || int'(dut.cnt) != ((c < MH - 1) ? c : MH - 1)) begin
                errors++;
                $display("FAIL lock c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
        end
        bus.lock = 1'b0;
    endtask
    task automatic test_scan();
        logic [9:0] orig, seq;
        do_reset();
        bus.req = 4'b0100;
        repeat (2) tick();
        orig = {m_gnt, 3'(m_cnt), 2'(m_ptr), m_st};
        seq = 10'b0001000011;
        se = 1'b1;
        for (int k = 0; k < 10; k++) begin
            si = seq[9 - k];
            tests++;
            if (so !== orig[9 - k]) begin
                errors++;
                $display("FAIL scan_out bit%0d: got %b required %b", k, so, orig[9 - k]);
            end
            tick();
        end
        se = 1'b0;
        si = 1'b0;
        tests++;
        if (obs_vec() !== exp_vec() || {dut.st, dut.ptr, dut.cnt, bus.gnt} !== {1'b1, 2'd1, 3'd0, 4'b0001}) begin
            errors++;
            $display("FAIL scan_load: got %b required %b", obs_vec(), exp_vec());
        end
        bus.req = '0;
        tick();
        tests++;
        if (obs_vec() !== exp_vec() || {dut.st, dut.ptr, bus.gnt} !== {1'b0, 2'd1, 4'b0000}) begin
            errors++;
            $display("FAIL scan_release: got %b required %b", obs_vec(), exp_vec());
        end
    endtask
    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            bus.req = 4'($urandom);
            bus.lock = ($urandom_range(0, 3) == 0);
            se = ($urandom_range(0, 7) == 0);
            si = 1'($urandom);
            if ($urandom_range(0, 60) == 0) do_reset();
            tick();
            tests++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random c%0d: got %b required %b", c, obs_vec(), exp_vec());
            end
        end
        se = 1'b0;
    endtask
    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_preempt();
        test_lock();
        test_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
